// File: rtl/pin_route_ctrl.sv
// pin_route_ctrl: run-time route table for the FPGA/periphery pin crossbar.
// Each periphery lane holds {sel, dir, en}. Updates to an enabled lane are
// applied break-before-make: the lane is disabled, a guard interval elapses,
// then the new route is written.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   cfg_valid/cfg_ready      route-update handshake
//   cfg_addr/sel/dir/en      requested lane and its new route
//   all_off                  synchronous kill of every lane enable
//   lane_sel/dir/en          route table driving the crossbar fabric
//   busy, done, cfg_err      update status (done/cfg_err are 1-cycle pulses)
module pin_route_ctrl #(
    parameter int unsigned N_PERIPH     = 21,
    parameter int unsigned N_FPGA       = 36,
    parameter int unsigned SEL_W        = 6,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ADDR_W-1:0]         cfg_addr,
    input  logic [SEL_W-1:0]          cfg_sel,
    input  logic                      cfg_dir,
    input  logic                      cfg_en,
    input  logic                      all_off,
    output logic [N_PERIPH*SEL_W-1:0] lane_sel,
    output logic [N_PERIPH-1:0]       lane_dir,
    output logic [N_PERIPH-1:0]       lane_en,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAKE  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    logic [ADDR_W-1:0]  lat_addr;
    logic [SEL_W-1:0]   lat_sel;
    logic               lat_dir;
    logic               lat_en;

    logic               lat_ld;
    logic               brk;
    logic               mk;
    logic               done_n;
    logic               err_n;

    logic               addr_ok;
    logic               sel_ok;
    logic [ADDR_W-1:0]  idx;
    logic [SEL_W-1:0]   cur_sel;
    logic               cur_dir;
    logic               cur_en;
    logic               req_noop;

    // Request classification against the current entry of the target lane.
    // idx is clamped so an out-of-range address never reads past the table.
    always_comb begin
        addr_ok  = 32'(cfg_addr) < N_PERIPH;
        sel_ok   = 32'(cfg_sel) < N_FPGA;
        idx      = addr_ok ? cfg_addr : '0;
        cur_sel  = lane_sel[32'(idx)*SEL_W +: SEL_W];
        cur_dir  = lane_dir[idx];
        cur_en   = lane_en[idx];
        req_noop = (!cfg_en && !cur_en) ||
                   ((cfg_sel == cur_sel) && (cfg_dir == cur_dir) && (cfg_en == cur_en));
    end

    // Next-state and datapath strobes; all_off overrides every state.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lat_ld  = 1'b0;
        brk     = 1'b0;
        mk      = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (all_off) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        if (!addr_ok || !sel_ok) begin
                            err_n = 1'b1;
                        end else if (req_noop) begin
                            done_n = 1'b1;
                        end else begin
                            lat_ld = 1'b1;
                            if (cur_en) begin
                                brk     = 1'b1;
                                cnt_n   = CNT_W'(GUARD_CYCLES - 1);
                                state_n = BREAK;
                            end else begin
                                state_n = MAKE;
                            end
                        end
                    end
                end
                BREAK: begin
                    if (cnt == '0) begin
                        state_n = MAKE;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                MAKE: begin
                    mk      = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State register and guard counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Request latch, route table and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr  <= '0;
            lat_sel   <= '0;
            lat_dir   <= 1'b0;
            lat_en    <= 1'b0;
            lane_sel  <= '0;
            lane_dir  <= '0;
            lane_en   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            busy      <= (state_n != IDLE);
            done      <= done_n;
            cfg_err   <= err_n;
            cfg_ready <= (state_n == IDLE) && !all_off;
            if (lat_ld) begin
                lat_addr <= cfg_addr;
                lat_sel  <= cfg_sel;
                lat_dir  <= cfg_dir;
                lat_en   <= cfg_en;
            end
            if (all_off) begin
                lane_en <= '0;
            end else begin
                if (brk) begin
                    lane_en[idx] <= 1'b0;
                end
                if (mk) begin
                    lane_sel[32'(lat_addr)*SEL_W +: SEL_W] <= lat_sel;
                    lane_dir[lat_addr]                     <= lat_dir;
                    lane_en[lat_addr]                      <= lat_en;
                end
            end
        end
    end

endmodule
